// File: rtl/reg_file_param.sv
// reg_file_param: parametrised multi-read single-write register file with clear sequencer
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clear_req,
  output logic                     busy,
  output logic                     wr_lost
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic wr_ok;
  assign busy = state == CLEAR;
  assign wr_ok = wr_en && !busy && !(ZERO_REG != 0 && wr_addr == '0);
  always_comb begin
    state_nx = state;
    state_nx = (state == CLEAR) ? ((clr_ptr == ADDR_W'(DEPTH - 1)) ? IDLE : CLEAR)
                                : (clear_req ? CLEAR : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      wr_lost <= 1'b0;
    end else begin
      state   <= state_nx;
      clr_ptr <= busy ? clr_ptr + 1'b1 : '0;
      wr_lost <= wr_lost | (wr_en & busy);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && busy) mem[clr_ptr] <= '0;
    else if (!rst && wr_ok) mem[wr_addr] <= wr_data;
  end
  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_data[k*DATA_W +: DATA_W] =
      (busy || (ZERO_REG != 0 && ra == '0)) ? '0 :
      (BYPASS != 0 && wr_en && wr_addr == ra) ? wr_data : mem[ra];
  end
endmodule
